issue_queue: RTL
================

# issue_queue

In-order issue queue that sits between decode/rename and the `ex` block. It buffers decoded instructions, tracks operand wake-up by snooping the ALU result bus, and drives the `ex_in_inf` issue interface, honouring each execution unit's `full` back-pressure. It is the transmitting end of `ex_in_inf`: one instruction is issued per cycle, at most, in program order.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous; discard all entries.
- `dec_valid`  in  1: decoded instruction offered.
- `dec_ready`  out  1: queue can accept; equals `count < DEPTH`.
- `dec_unit`  in  `EX_UNIT_NUM_WIDTH`: target execution unit.
- `dec_target`  in  `INST_TAG_WIDTH`: destination ROB tag.
- `dec_val[1:2]`  in  `COMMON_WIDTH` each: operand values (meaningful when tag invalid).
- `dec_tag[1:2]`  in  `INST_TAG_WIDTH` each: producer tags; `TAG_INVALID` = operand ready.
- `dec_op`  in  `OP_TYPE_WIDTH`: operation.
- `cdb`  `ex_alu_out_inf.in`: ALU result broadcast (`target`, `result`).
- `full[0:EX_UNIT_NUM-1]`  in  1 each: unit reservation station full.
- `out`  `ex_in_inf.out`: issue port (`ce`, `unit`, `target`, `val`, `tag`, `op`).

## Operation
- Circular buffer, `DEPTH` entries, head/tail pointers `log2(DEPTH)` bits plus `count` of `log2(DEPTH)+1` bits; pointers wrap modulo `DEPTH`.
- Push: `dec_valid && dec_ready` writes the entry at tail on the clock edge.
- Issue (combinational from head): `out.ce = (count != 0) && !full[head.unit] && !flush`. The unit captures on the same edge. The head pops on that edge iff `out.ce`.
- `out` fields always reflect the head entry. When the queue is empty: `out.target = TAG_INVALID`, `out.tag = TAG_INVALID`, all other fields are 0.
- Wake-up: when `cdb.target != TAG_INVALID`, every valid entry operand `k` with `tag[k] == cdb.target` loads `val[k] <= cdb.result` and `tag[k] <= TAG_INVALID` on the edge.
- Same-cycle cases:
  - Push with a matching `dec_tag` stores the woken value and `TAG_INVALID`.
  - The head operand on `out` is forwarded combinationally from `cdb` when it matches.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance. Push is impossible when full because `dec_ready` is low, even if a pop occurs.
- `flush` has priority over push, pop and wake-up: `count`, head and tail go to 0, `out.ce` is 0 that cycle, and `dec_ready` is unaffected that cycle.
- No reordering: a blocked head blocks all younger entries, including those bound for other units.

## Timing
- Reset (async assert, sync release): `count = 0`, head = tail = 0, `out.ce = 0`, `out.target/tag = TAG_INVALID`, other `out` fields 0, `dec_ready = 1`. Entry storage is not reset.
- Latency: a push accepted at edge E0 issues with `out.ce = 1` in the cycle after E0 (captured at E1) if the queue was empty and `full[unit] = 0`.
- Throughput: 1 issue/cycle while the head's unit is not full.
- `full` is sampled combinationally each cycle; a unit asserting `full` in cycle N blocks issue in cycle N.
- `dec_ready` is combinational from registered `count` only; it has no path from `dec_valid`.

## Structure
- Add to the shared package/header: an `issue_entry_t` struct (`unit`, `target`, `val[1:2]`, `tag[1:2]`, `op`) and the helper `tag_match(tag, cdb_target)`, which excludes `TAG_INVALID`. Reuse the existing `TAG_INVALID`, `EX_ALU_UNIT` and width macros.
- One sub-module is natural: `issue_entry_wakeup`, a per-entry operand compare-and-capture instantiated `DEPTH` times plus once on the push path.

## Test plan
- Reset mid-stream with 3 entries queued: assert `rst` → `out.ce = 0` and `dec_ready = 1` immediately; after release, `count = 0`.
- Push ALU op with tags invalid and vals 5/7, `full = 0` → `out.ce = 1` next cycle with vals 5/7 and the matching target.
- Fill 4 entries with `full[ALU] = 1` → `dec_ready = 0`, `out.ce = 0`, and the head is held. Deassert `full` → 4 consecutive `ce` pulses in push order, and `dec_ready` rises after the first pop.
- Entry queued with `tag[1] = 3`; `cdb.target = 3`, `result = 0xAB` → the issued op shows `val[1] = 0xAB` and `tag[1] = TAG_INVALID`. Repeat with the match on the push cycle and on the issue cycle.
- `flush` asserted together with push, pop and a cdb match at `count = 2` → `count = 0` next cycle, `ce = 0` that cycle, and no entry survives.
- Wrap-around: 10 push/pop pairs at `count = 1` steady state → issue order exactly matches push order.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared types and widths for the in-order issue queue and its ex-side issue port.
// The head operands are woken and forwarded through the same compare helper used in storage.
package issue_queue_pkg;

    localparam int EX_UNIT_NUM       = 4;
    localparam int EX_UNIT_NUM_WIDTH = 2;
    localparam int INST_TAG_WIDTH    = 5;
    localparam int COMMON_WIDTH      = 32;
    localparam int OP_TYPE_WIDTH     = 4;

    localparam logic [INST_TAG_WIDTH-1:0]    TAG_INVALID = '1;
    localparam logic [EX_UNIT_NUM_WIDTH-1:0] EX_ALU_UNIT = '0;

    typedef struct packed {
        logic [EX_UNIT_NUM_WIDTH-1:0]         unit;
        logic [INST_TAG_WIDTH-1:0]            target;
        logic [1:2][COMMON_WIDTH-1:0]         val;
        logic [1:2][INST_TAG_WIDTH-1:0]       tag;
        logic [OP_TYPE_WIDTH-1:0]             op;
    } issue_entry_t;

    // A broadcast of TAG_INVALID carries no result and must never wake an operand.
    function automatic logic tag_match(input logic [INST_TAG_WIDTH-1:0] tag,
                                       input logic [INST_TAG_WIDTH-1:0] cdb_target);
        return (cdb_target != TAG_INVALID) && (tag == cdb_target);
    endfunction

endpackage

// File: rtl/issue_entry_wakeup.sv
// Operand compare-and-capture for one queue entry: replaces any operand waiting on
// the broadcast tag with the broadcast result and marks it ready.
module issue_entry_wakeup
    import issue_queue_pkg::*;
(
    input  issue_entry_t              i_entry,
    input  logic [INST_TAG_WIDTH-1:0] i_cdb_target,
    input  logic [COMMON_WIDTH-1:0]   i_cdb_result,
    output issue_entry_t              o_entry
);

    always_comb begin
        o_entry = i_entry;
        if (tag_match(i_entry.tag[1], i_cdb_target)) begin
            o_entry.val[1] = i_cdb_result;
            o_entry.tag[1] = TAG_INVALID;
        end
        if (tag_match(i_entry.tag[2], i_cdb_target)) begin
            o_entry.val[2] = i_cdb_result;
            o_entry.tag[2] = TAG_INVALID;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue between rename and the execution units: circular buffer with
// operand wake-up from the ALU result bus and one issue per cycle from the head.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         dec_valid,
    output logic                         dec_ready,
    input  logic [EX_UNIT_NUM_WIDTH-1:0] dec_unit,
    input  logic [INST_TAG_WIDTH-1:0]    dec_target,
    input  logic [COMMON_WIDTH-1:0]      dec_val [1:2],
    input  logic [INST_TAG_WIDTH-1:0]    dec_tag [1:2],
    input  logic [OP_TYPE_WIDTH-1:0]     dec_op,
    input  logic [INST_TAG_WIDTH-1:0]    cdb_target,
    input  logic [COMMON_WIDTH-1:0]      cdb_result,
    input  logic [EX_UNIT_NUM-1:0]       full,
    output logic                         out_ce,
    output logic [EX_UNIT_NUM_WIDTH-1:0] out_unit,
    output logic [INST_TAG_WIDTH-1:0]    out_target,
    output logic [COMMON_WIDTH-1:0]      out_val [1:2],
    output logic [INST_TAG_WIDTH-1:0]    out_tag [1:2],
    output logic [OP_TYPE_WIDTH-1:0]     out_op,
    output logic [$clog2(DEPTH):0]       dbg_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    issue_entry_t     r_mem [DEPTH];

    issue_entry_t     w_woken [DEPTH];
    issue_entry_t     w_push_raw;
    issue_entry_t     w_push_entry;
    issue_entry_t     w_head;
    logic             w_empty;
    logic             w_push;
    logic             w_issue;

    always_comb begin
        w_push_raw        = '0;
        w_push_raw.unit   = dec_unit;
        w_push_raw.target = dec_target;
        w_push_raw.val[1] = dec_val[1];
        w_push_raw.val[2] = dec_val[2];
        w_push_raw.tag[1] = dec_tag[1];
        w_push_raw.tag[2] = dec_tag[2];
        w_push_raw.op     = dec_op;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        issue_entry_wakeup u_wake (
            .i_entry      (r_mem[g]),
            .i_cdb_target (cdb_target),
            .i_cdb_result (cdb_result),
            .o_entry      (w_woken[g])
        );
    end

    issue_entry_wakeup u_push_wake (
        .i_entry      (w_push_raw),
        .i_cdb_target (cdb_target),
        .i_cdb_result (cdb_result),
        .o_entry      (w_push_entry)
    );

    assign w_empty   = (r_count == '0);
    assign w_head    = w_woken[r_head];
    assign dec_ready = (r_count < (PTR_W+1)'(DEPTH));
    assign w_push    = dec_valid && dec_ready && !flush;
    assign w_issue   = !w_empty && !full[w_head.unit] && !flush;
    assign dbg_count = r_count;

    // The woken head drives the port so a same-cycle broadcast is forwarded to the unit.
    always_comb begin
        out_ce     = w_issue;
        out_unit   = '0;
        out_target = TAG_INVALID;
        out_val[1] = '0;
        out_val[2] = '0;
        out_tag[1] = TAG_INVALID;
        out_tag[2] = TAG_INVALID;
        out_op     = '0;
        if (!w_empty) begin
            out_unit   = w_head.unit;
            out_target = w_head.target;
            out_val[1] = w_head.val[1];
            out_val[2] = w_head.val[2];
            out_tag[1] = w_head.tag[1];
            out_tag[2] = w_head.tag[2];
            out_op     = w_head.op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + 1'b1;
            if (w_issue)
                r_head <= r_head + 1'b1;
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; entries outside [head, tail) are dead and never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= w_woken[i];
        if (w_push)
            r_mem[r_tail] <= w_push_entry;
    end

endmodule
